// File: rtl/parity_pkg.sv
// Types and constants shared by the parity-protected byte path
// (frame transmitter, parity checker and their benches).
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DATA_W_DEF = 8;
  // start + data + parity + stop
  localparam int FRAME_BITS = DATA_W_DEF + 3;

endpackage

// File: rtl/parity_gen.sv
// Parity bit for one data word; the receive-side checker instantiates this
// same block so both ends agree on the definition.
module parity_gen #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  localparam logic OddSel = (ODD_PARITY != 0);

  assign parity_o = (^data_i) ^ OddSel;

endmodule

// File: rtl/parity_frame_tx.sv
// Byte-to-serial framer: start bit, DATA_W data bits LSB first, parity bit,
// stop bit, each held CLKS_PER_BIT clocks. Line idles high.
//
// Handshake: a byte is transferred on the rising clk edge where
// in_valid && in_ready; in_ready is high only while the framer is idle,
// and in_valid/in_data are ignored at every other time.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        frame_count,
  output logic [2:0]        state_dbg
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     idx_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        count_q;

  logic par_d;
  logic bit_end;

  parity_gen #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_gen (
    .data_i   (in_data),
    .parity_o (par_d)
  );

  assign bit_end = (timer_q == TimerLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      timer_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        timer_q <= bit_end ? '0 : timer_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (in_valid && ready_q) begin
            shift_q <= in_data;
            par_q   <= par_d;
            timer_q <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == IdxLast) begin
              tx_q    <= par_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            count_q <= count_q + 4'd1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = ready_q;
  assign tx_out      = tx_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: even/odd framing, back-to-back,
// async reset abort, input-hold independence and counter wrap at 1 clk/bit.
module tb_parity_frame_tx;
  import parity_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [7:0] din;
  logic       vld  [3];
  logic       rdy  [3];
  logic       tx   [3];
  logic       bsy  [3];
  logic       done [3];
  logic [3:0] cnt  [3];
  logic [2:0] st   [3];

  logic [7:0] rx_byte;
  logic       rx_par;
  logic       chk_par;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // unit 0: even, 4 clk/bit; unit 1: odd, 4 clk/bit; unit 2: even, 1 clk/bit
  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(int'(PARITY_EVEN))) u_even (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .in_data(din), .in_ready(rdy[0]),
    .tx_out(tx[0]), .busy(bsy[0]), .frame_done(done[0]), .frame_count(cnt[0]), .state_dbg(st[0]));

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(int'(PARITY_ODD))) u_odd (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .in_data(din), .in_ready(rdy[1]),
    .tx_out(tx[1]), .busy(bsy[1]), .frame_done(done[1]), .frame_count(cnt[1]), .state_dbg(st[1]));

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .ODD_PARITY(int'(PARITY_EVEN))) u_fast (
    .clk(clk), .reset(reset), .in_valid(vld[2]), .in_data(din), .in_ready(rdy[2]),
    .tx_out(tx[2]), .busy(bsy[2]), .frame_done(done[2]), .frame_count(cnt[2]), .state_dbg(st[2]));

  // receive-side checker configured for odd parity
  parity_gen #(.DATA_W(8), .ODD_PARITY(int'(PARITY_ODD))) u_chk (
    .data_i(rx_byte), .parity_o(chk_par));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int k, input logic [3:0] exp_cnt, input string tag);
    check({tag, " line/busy/ready/done"}, {tx[k], bsy[k], rdy[k], done[k]}, 4'b1010);
    check({tag, " count"}, cnt[k], exp_cnt);
    check({tag, " state"}, st[k], 3'd0);
  endtask

  // Offer one byte from an idle negedge, follow every cycle of the frame and
  // stop on the negedge of the first idle cycle (frame_done high there).
  task automatic send_frame(input int k, input logic [7:0] data, input logic exp_par,
                            input logic [3:0] exp_cnt, input bit hold,
                            input bit change, input logic [7:0] alt);
    int         cpb;
    int         len;
    int         b;
    logic [10:0] bits;
    cpb  = (k == 2) ? 1 : 4;
    len  = FRAME_BITS * cpb;
    bits = {1'b1, exp_par, data, 1'b0};
    check($sformatf("u%0d pre ready/line", k), {rdy[k], tx[k]}, 2'b11);
    din    = data;
    vld[k] = 1'b1;
    @(negedge clk);
    if (!hold) vld[k] = 1'b0;
    if (change) din = alt;
    for (int m = 0; m < len; m++) begin
      b = m / cpb;
      check($sformatf("u%0d d=%0h m=%0d tx", k, data, m), tx[k], bits[b]);
      check($sformatf("u%0d d=%0h m=%0d busy/ready/done", k, data, m),
            {bsy[k], rdy[k], done[k]}, 3'b100);
      if ((m % cpb) == 0) begin
        if (b >= 1 && b <= 8) rx_byte[b-1] = tx[k];
        if (b == 9) rx_par = tx[k];
      end
      @(negedge clk);
    end
    check($sformatf("u%0d d=%0h end line/busy/ready/done", k, data),
          {tx[k], bsy[k], rdy[k], done[k]}, 4'b1011);
    check($sformatf("u%0d d=%0h end count", k, data), cnt[k], exp_cnt);
  endtask

  initial begin
    logic [7:0] d;
    din = 8'h00;
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    rx_byte = 8'h00;
    rx_par  = 1'b0;

    // async reset with no clock edge in between
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_idle(k, 4'd0, $sformatf("u%0d reset", k));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // odd parity: 0x1F -> 0, 0x00 -> 1, odd checker matches
    send_frame(1, 8'h1F, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00);
    #1;
    check("odd 1F rx byte", rx_byte, 8'h1F);
    check("odd 1F loopback match", (chk_par == rx_par), 1'b1);
    @(negedge clk);
    send_frame(1, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00);
    #1;
    check("odd 00 rx byte", rx_byte, 8'h00);
    check("odd 00 loopback match", (chk_par == rx_par), 1'b1);
    @(negedge clk);

    // even parity 0x1F: 0 | 11111000 | 1 | 1
    send_frame(0, 8'h1F, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_idle(0, 4'd1, "even 1F after");

    // in_data moved after acceptance must not reach the line
    send_frame(0, 8'h0F, 1'b0, 4'd2, 1'b0, 1'b1, 8'hF0);
    @(negedge clk);

    // reset during data bit 3 of 0xAA
    din    = 8'hAA;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("abort pre bit3 tx", tx[0], 1'b1);
    check("abort pre busy", bsy[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    check_idle(0, 4'd0, "abort immediate");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort no done", done[0], 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, 4'd0, "abort released");
    send_frame(0, 8'h55, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // plain reset pulse then back-to-back with in_valid held
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, 4'd0, "b2b start");
    send_frame(0, 8'h22, 1'b0, 4'd1, 1'b1, 1'b0, 8'h00);
    send_frame(0, 8'h44, 1'b0, 4'd2, 1'b1, 1'b0, 8'h00);
    send_frame(0, 8'h66, 1'b0, 4'd3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check_idle(0, 4'd3, "b2b end");

    // 17 back-to-back frames at 1 clk/bit: counter wraps 15 -> 0
    check_idle(2, 4'd0, "wrap start");
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 37 + 3);
      send_frame(2, d, ^d, 4'(i + 1), (i < 16), 1'b0, 8'h00);
    end
    @(negedge clk);
    check_idle(2, 4'd1, "wrap end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
